// File: rtl/regbank_write_queue.sv
// regbank_write_queue: in-order write-back FIFO draining up to two results per cycle into the register bank.
// Define REGBANK_WQ_FORWARDING_EN to return the youngest pending value on lookupData.
module regbank_write_queue #(
  parameter int DEPTH        = 4,
  parameter int REGNUM_WIDTH = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pushValid,
  output logic                         pushReady,
  input  logic [REGNUM_WIDTH-1:0]      pushRegNum,
  input  logic [DATA_WIDTH-1:0]        pushData,
  output logic                         writeEnable0,
  output logic [REGNUM_WIDTH-1:0]      regNum0,
  output logic [DATA_WIDTH-1:0]        dataOut0,
  output logic                         writeEnable1,
  output logic [REGNUM_WIDTH-1:0]      regNum1,
  output logic [DATA_WIDTH-1:0]        dataOut1,
  input  logic [REGNUM_WIDTH-1:0]      lookupRegNum,
  output logic                         lookupHit,
  output logic [DATA_WIDTH-1:0]        lookupData,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [REGNUM_WIDTH-1:0] regMem  [DEPTH];
  logic [DATA_WIDTH-1:0]   dataMem [DEPTH];

  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] nxtPtr;
  logic [CW-1:0] cnt;
  logic          pushAcc;
  logic          pair;
  logic [1:0]    pops;
  logic          hit;

  assign nxtPtr  = rdPtr + PW'(1);
  assign pushReady = (cnt < CW'(DEPTH)) && !reset;
  // x0 results are acknowledged but never stored
  assign pushAcc = pushValid && pushReady
                 && (pushRegNum != '0);

  // second port only when the next entry targets a different register
  assign pair = (cnt >= CW'(2))
              && (regMem[nxtPtr] != regMem[rdPtr]);
  assign writeEnable0 = (cnt != '0) && !reset;
  assign writeEnable1 = writeEnable0 && pair;
  assign pops = {1'b0, writeEnable0}
              + {1'b0, writeEnable1};

  assign regNum0  = writeEnable0 ? regMem[rdPtr]   : '0;
  assign dataOut0 = writeEnable0 ? dataMem[rdPtr]  : '0;
  assign regNum1  = writeEnable1 ? regMem[nxtPtr]  : '0;
  assign dataOut1 = writeEnable1 ? dataMem[nxtPtr] : '0;

  assign count = cnt;
  assign empty = (cnt == '0);

  // match scan over valid entries, oldest to youngest
  always_comb begin
    logic [PW-1:0] idx;
    hit = 1'b0;
    idx = rdPtr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PW'(i);
      if ((CW'(i) < cnt)
          && (regMem[idx] == lookupRegNum))
        hit = 1'b1;
    end
  end

  assign lookupHit = hit && !reset
                   && (lookupRegNum != '0);

`ifdef REGBANK_WQ_FORWARDING_EN
  logic [DATA_WIDTH-1:0] hitData;

  // youngest match wins, so later entries overwrite
  always_comb begin
    logic [PW-1:0] idx;
    hitData = '0;
    idx = rdPtr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PW'(i);
      if ((CW'(i) < cnt)
          && (regMem[idx] == lookupRegNum))
        hitData = dataMem[idx];
    end
  end

  assign lookupData = lookupHit ? hitData : '0;
`else
  assign lookupData = '0;
`endif

  // entry storage, written at the tail on accepted pushes
  always_ff @(posedge clk) begin
    if (pushAcc) begin
      regMem[wrPtr]  <= pushRegNum;
      dataMem[wrPtr] <= pushData;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else begin
      if (pushAcc)
        wrPtr <= wrPtr + PW'(1);
      rdPtr <= rdPtr + PW'(pops);
      cnt   <= cnt + CW'(pushAcc) - CW'(pops);
    end
  end

endmodule

// File: tb/tb_regbank_write_queue.sv
// tb_regbank_write_queue: scoreboard bench for regbank_write_queue.
// Expected bank writes are queued on push and retired as the DUT drains.
module tb_regbank_write_queue;

  localparam int DEPTH = 4;
  localparam int RW    = 4;
  localparam int DW    = 32;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          pushValid;
  logic          pushReady;
  logic [RW-1:0] pushRegNum;
  logic [DW-1:0] pushData;
  logic          writeEnable0;
  logic [RW-1:0] regNum0;
  logic [DW-1:0] dataOut0;
  logic          writeEnable1;
  logic [RW-1:0] regNum1;
  logic [DW-1:0] dataOut1;
  logic [RW-1:0] lookupRegNum;
  logic          lookupHit;
  logic [DW-1:0] lookupData;
  logic [CW-1:0] count;
  logic          empty;

  typedef struct packed {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regbank_write_queue #(
    .DEPTH(DEPTH),
    .REGNUM_WIDTH(RW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pushValid(pushValid),
    .pushReady(pushReady),
    .pushRegNum(pushRegNum),
    .pushData(pushData),
    .writeEnable0(writeEnable0),
    .regNum0(regNum0),
    .dataOut0(dataOut0),
    .writeEnable1(writeEnable1),
    .regNum1(regNum1),
    .dataOut1(dataOut1),
    .lookupRegNum(lookupRegNum),
    .lookupHit(lookupHit),
    .lookupData(lookupData),
    .count(count),
    .empty(empty)
  );

  // one clock: check outputs against the model, then advance both
  task automatic step();
    int     pops;
    logic   acc;
    logic   ehit;
    logic [DW-1:0] edata;
    ent_t   e;
    pops = 0;
    acc  = 1'b0;
    #1;
    if (reset) begin
      total++;
      if (writeEnable0 !== 1'b0 || writeEnable1 !== 1'b0
          || lookupHit !== 1'b0 || pushReady !== 1'b0) begin
        bad++;
        $display("FAIL rst_outs got we0=%b we1=%b hit=%b rdy=%b want 0000",
                 writeEnable0, writeEnable1, lookupHit, pushReady);
      end
    end else begin
      total++;
      if (pushReady !== (q.size() < DEPTH)) begin
        bad++;
        $display("FAIL ready got %b want %b", pushReady, q.size() < DEPTH);
      end
      total++;
      if (count !== CW'(q.size()) || empty !== (q.size() == 0)) begin
        bad++;
        $display("FAIL count got %0d/%b want %0d/%b",
                 count, empty, q.size(), q.size() == 0);
      end
      total++;
      if (q.size() >= 1) begin
        pops = 1;
        if (writeEnable0 !== 1'b1 || regNum0 !== q[0].r
            || dataOut0 !== q[0].d) begin
          bad++;
          $display("FAIL port0 got %b r%0d %h want 1 r%0d %h",
                   writeEnable0, regNum0, dataOut0, q[0].r, q[0].d);
        end
      end else if (writeEnable0 !== 1'b0 || regNum0 !== '0
                   || dataOut0 !== '0) begin
        bad++;
        $display("FAIL port0_idle got %b r%0d %h want 0 r0 0",
                 writeEnable0, regNum0, dataOut0);
      end
      total++;
      if (q.size() >= 2 && q[1].r != q[0].r) begin
        pops = 2;
        if (writeEnable1 !== 1'b1 || regNum1 !== q[1].r
            || dataOut1 !== q[1].d) begin
          bad++;
          $display("FAIL port1 got %b r%0d %h want 1 r%0d %h",
                   writeEnable1, regNum1, dataOut1, q[1].r, q[1].d);
        end
      end else if (writeEnable1 !== 1'b0 || regNum1 !== '0
                   || dataOut1 !== '0) begin
        bad++;
        $display("FAIL port1_idle got %b r%0d %h want 0 r0 0",
                 writeEnable1, regNum1, dataOut1);
      end
      ehit  = 1'b0;
      edata = '0;
      if (lookupRegNum != '0)
        foreach (q[i])
          if (q[i].r == lookupRegNum) begin
            ehit  = 1'b1;
            edata = q[i].d;
          end
`ifndef REGBANK_WQ_FORWARDING_EN
      edata = '0;
`endif
      total++;
      if (lookupHit !== ehit || lookupData !== edata) begin
        bad++;
        $display("FAIL lookup r%0d got %b %h want %b %h",
                 lookupRegNum, lookupHit, lookupData, ehit, edata);
      end
      acc = pushValid && (q.size() < DEPTH) && (pushRegNum != '0);
      e.r = pushRegNum;
      e.d = pushData;
    end
    @(posedge clk);
    if (reset) q.delete();
    else begin
      repeat (pops) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic idle_inputs();
    pushValid    = 1'b0;
    pushRegNum   = '0;
    pushData     = '0;
    lookupRegNum = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    #1;
    total++;
    if (count !== 0 || empty !== 1'b1 || pushReady !== 1'b1
        || writeEnable0 !== 1'b0 || writeEnable1 !== 1'b0
        || lookupHit !== 1'b0) begin
      bad++;
      $display("FAIL idle got cnt=%0d e=%b rdy=%b we=%b%b hit=%b",
               count, empty, pushReady, writeEnable0,
               writeEnable1, lookupHit);
    end
    step();
  endtask

  task automatic test_single();
    pushValid  = 1'b1;
    pushRegNum = 4'd3;
    pushData   = 32'h11;
    step();
    idle_inputs();
    #1;
    total++;
    if (writeEnable0 !== 1'b1 || regNum0 !== 4'd3
        || dataOut0 !== 32'h11 || writeEnable1 !== 1'b0) begin
      bad++;
      $display("FAIL single got %b r%0d %h we1=%b want 1 r3 11 0",
               writeEnable0, regNum0, dataOut0, writeEnable1);
    end
    step();
    #1;
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL single_empty got %b want 1", empty);
    end
    step();
  endtask

  task automatic test_stream();
    logic [RW-1:0] rs [6];
    logic [DW-1:0] ds [6];
    rs = '{4'd1, 4'd2, 4'd1, 4'd4, 4'd1, 4'd1};
    ds = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hA, 32'hC};
    for (int i = 0; i < 6; i++) begin
      pushValid  = 1'b1;
      pushRegNum = rs[i];
      pushData   = ds[i];
      step();
    end
    idle_inputs();
    repeat (3) step();
  endtask

  task automatic test_x0();
    pushValid  = 1'b1;
    pushRegNum = '0;
    pushData   = 32'hDEAD;
    #1;
    total++;
    if (pushReady !== 1'b1) begin
      bad++;
      $display("FAIL x0_ready got %b want 1", pushReady);
    end
    step();
    idle_inputs();
    #1;
    total++;
    if (count !== 0 || writeEnable0 !== 1'b0) begin
      bad++;
      $display("FAIL x0_drop got cnt=%0d we0=%b want 0 0",
               count, writeEnable0);
    end
    repeat (2) step();
  endtask

  task automatic test_lookup();
    pushValid    = 1'b1;
    pushRegNum   = 4'd5;
    pushData     = 32'd1;
    lookupRegNum = 4'd5;
    step();
    pushData = 32'd2;
    step();
    pushValid = 1'b0;
    #1;
    total++;
    if (lookupHit !== 1'b1) begin
      bad++;
      $display("FAIL lk_hit got %b want 1", lookupHit);
    end
    total++;
`ifdef REGBANK_WQ_FORWARDING_EN
    if (lookupData !== 32'd2) begin
`else
    if (lookupData !== 32'd0) begin
`endif
      bad++;
      $display("FAIL lk_data got %h", lookupData);
    end
    lookupRegNum = '0;
    #1;
    total++;
    if (lookupHit !== 1'b0) begin
      bad++;
      $display("FAIL lk_zero got %b want 0", lookupHit);
    end
    step();
    lookupRegNum = 4'd5;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    pushValid  = 1'b1;
    pushRegNum = 4'd7;
    pushData   = 32'h77;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++;
    if (count !== 0 || writeEnable0 !== 1'b0
        || writeEnable1 !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got cnt=%0d we=%b%b want 0 00",
               count, writeEnable0, writeEnable1);
    end
    repeat (2) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      pushValid    = ($urandom_range(0, 3) != 0);
      pushRegNum   = RW'($urandom_range(0, 3));
      pushData     = $urandom;
      lookupRegNum = RW'($urandom_range(0, 3));
      step();
    end
    idle_inputs();
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_x0();
    test_lookup();
    test_reset_mid();
    test_random();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
